uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling asynchronous serial receiver, the downstream peer of the team's UART transmitter. It recovers frames from the serial line (`RX_IN`), converts them to parallel bytes, and checks the optional parity bit and the stop bit. Frame format: start(0), 8 data bits LSB first, optional parity, stop(1). `CLK` runs at `prescale` × bit rate. Output feeds the RX byte consumer / FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data bits per frame.

Ports:
- `CLK`  in  1  receiver clock; `prescale` × bit rate.
- `RST`  in  1  reset; synchronous to `CLK`, active-high.
- `RX_IN`  in  1  serial line; idle high; asynchronous to `CLK`.
- `prescale`  in  6  oversampling ratio; legal values 8, 16, 32.
- `parity_enable`  in  1  1 = frame carries a parity bit.
- `parity_type`  in  1  0 = even, 1 = odd.
- `P_DATA`  out  `DATA_WIDTH`  last good byte; held until the next good frame.
- `data_valid`  out  1  one-cycle pulse when `P_DATA` updates.
- `parity_error`  out  1  one-cycle pulse for a parity mismatch.
- `stop_error`  out  1  one-cycle pulse when the stop bit is sampled 0.
- `busy`  out  1  high while a frame is in progress.

## Operation
- **Input synchronizer.** `RX_IN` passes through a 2-flop synchronizer (`rx_s`). All logic below uses `rx_s`.
- **Frame config latch.** `prescale`, `parity_enable` and `parity_type` are latched on the IDLE→START transition and held for the whole frame.
- **Counters.**
  - `edge_cnt` counts 0..P-1 within each bit.
  - `bit_cnt` counts 0..DATA_WIDTH-1 during DATA.
- **Bit sampling.** Samples are taken at `edge_cnt` = P/2-1, P/2, P/2+1. The bit decision is made at `edge_cnt` = P/2+2.
- **State machine.**
  - IDLE: when `rx_s`=0, go to START with `edge_cnt`=0 in that cycle.
  - START: at the decision point, if the bit is 1 (glitch), go to IDLE with no outputs. If the bit is 0, continue to the bit end (`edge_cnt`=P-1), then go to DATA.
  - DATA: at each decision, shift the bit into the shift register at position `bit_cnt` (LSB first). After bit DATA_WIDTH-1 ends, go to PARITY if `parity_enable`, otherwise to STOP.
  - PARITY: the expected bit is ^data for even (`parity_type`=0) or ~^data for odd (`parity_type`=1). A mismatch is recorded. At the bit end, go to STOP.
  - STOP: at the decision point, go to IDLE immediately, half a bit early, so a back-to-back start edge is caught. On the next cycle exactly one of the following happens:
    - `data_valid`=1 and `P_DATA` updates, if there was no parity mismatch and the stop bit is 1;
    - otherwise `parity_error` and/or `stop_error` pulse for one cycle, and `P_DATA` is unchanged.
- **`busy`.** Registered. High from the START entry cycle until the IDLE return; low in IDLE.
- **Line held low.** Each frame ends with `stop_error`, then the FSM immediately restarts. This repeats until the line goes high.
- **Illegal `prescale`.** Values other than 8, 16, 32 are unsupported; behaviour is undefined.
- **Reset.** `RST` mid-frame aborts the frame. All state returns to IDLE and the synchronizer resets to 1.

## Timing
- Reset values:
  - `P_DATA`=0, `data_valid`=0, `parity_error`=0, `stop_error`=0, `busy`=0.
  - State IDLE, counters 0, synchronizer flops 1.
- Latency from the `RX_IN` falling edge to the `data_valid` / error pulse is (9 + `parity_enable`)·P + P/2 + 5 CLK. For P=8 with no parity this is 81 cycles.
- `busy` rises 3 CLK after the `RX_IN` falling edge (2 synchronizer stages + the state register).
- The output pulses are exactly 1 cycle wide. No handshake: the consumer must accept `data_valid` when it occurs.
- Minimum frame spacing: a start bit that begins immediately after a full-length stop bit is received correctly.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit is the 2-of-3 majority of the three samples.
- Undefined: each bit is the single sample at `edge_cnt`=P/2. The decision point stays at P/2+2, so cycle timing is identical in both builds.

## Test plan
- P=8, no parity, send 0xA5 → one `data_valid` pulse 81 CLK after the start edge, `P_DATA`=0xA5, no errors.
- P=16, even parity, 0x3C with parity bit 0 → `data_valid`, `P_DATA`=0x3C. The same frame with parity bit 1 → `parity_error` pulse, no `data_valid`, `P_DATA` keeps its old value.
- P=8, 0x0F with stop bit 0 → `stop_error` pulse only. The line then returns high and the next 0x81 frame is received correctly.
- P=16, `RX_IN` low for 3 CLK then high → `busy` pulses briefly, FSM returns to IDLE, no output pulses. With the macro on, a 1-CLK low spike landing in the sample window during DATA does not corrupt bit 0x55.
- P=32, odd parity, back-to-back 0x55 then 0xAA with a single stop bit between them → two `data_valid` pulses carrying the correct bytes; `busy` drops for less than one bit time.
- `RST`=1 for 1 cycle in the middle of DATA → all outputs 0 and state IDLE on the next cycle. The remainder of the aborted frame causes at most a `stop_error` or a glitch reject, never a false `data_valid`.

Source files
------------

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial line, per-frame configuration and received-byte outputs
// of uart_rx so that they travel as one port.
//   RX_IN          serial line, idle high, asynchronous to the receiver clock
//   prescale       oversampling ratio (8, 16 or 32 clocks per bit)
//   parity_enable  1 = frame carries a parity bit
//   parity_type    0 = even, 1 = odd
//   P_DATA         last good byte, held until the next good frame
//   data_valid     one-cycle pulse when P_DATA updates
//   parity_error   one-cycle pulse on a parity mismatch
//   stop_error     one-cycle pulse when the stop bit is sampled low
//   busy           high while a frame is in progress
// Modports: master = line driver / byte consumer, slave = the receiver.
// ----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;

    modport master (
        output RX_IN, prescale, parity_enable, parity_type,
        input  P_DATA, data_valid, parity_error, stop_error, busy
    );

    modport slave (
        input  RX_IN, prescale, parity_enable, parity_type,
        output P_DATA, data_valid, parity_error, stop_error, busy
    );
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Oversampling asynchronous serial receiver. Recovers start/data/[parity]/stop
// frames (data LSB first) from the serial line, presents each good byte on
// P_DATA with a data_valid pulse, and flags parity and stop-bit errors.
// Ports:
//   CLK  receiver clock, prescale x bit rate
//   RST  synchronous active-high reset
//   bus  uart_rx_if.slave (RX_IN, prescale, parity_enable, parity_type in;
//        P_DATA, data_valid, parity_error, stop_error, busy out)
// Build option:
//   UART_RX_MAJORITY_EN  defined: each bit is the 2-of-3 majority of the
//                        samples at P/2-1, P/2, P/2+1; undefined: the single
//                        sample at P/2. Cycle timing is the same either way.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                r_state, w_next;
    logic                  r_sync1, r_rx_s;
    logic [5:0]            r_prescale;
    logic                  r_pen, r_ptype;
    logic [5:0]            r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_err;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic                  r_dv, r_pe, r_se, r_busy;

    logic       w_start, w_shift_en, w_par_chk, w_frame_done;
    logic       w_bit, w_exp_par, w_at_dec, w_at_end;
    logic [5:0] w_half;

    assign w_half    = {1'b0, r_prescale[5:1]};
    assign w_at_dec  = (r_edge_cnt == w_half + 6'd2);
    assign w_at_end  = (r_edge_cnt == r_prescale - 6'd1);
    assign w_exp_par = r_ptype ? ~^r_shift : ^r_shift;

    // two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.RX_IN;
            r_rx_s  <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] r_samp;
    logic [5:0] w_samp_lo, w_samp_hi;
    assign w_samp_lo = w_half - 6'd1;
    assign w_samp_hi = w_half + 6'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_samp <= 3'b111;
        end else begin
            if (r_edge_cnt == w_samp_lo) r_samp[0] <= r_rx_s;
            if (r_edge_cnt == w_half)    r_samp[1] <= r_rx_s;
            if (r_edge_cnt == w_samp_hi) r_samp[2] <= r_rx_s;
        end
    end

    assign w_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) |
                   (r_samp[1] & r_samp[2]);
`else
    logic r_samp_mid;

    always_ff @(posedge CLK) begin
        if (RST)                          r_samp_mid <= 1'b1;
        else if (r_edge_cnt == w_half)    r_samp_mid <= r_rx_s;
    end

    assign w_bit = r_samp_mid;
`endif

    // state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state and per-cycle strobes
    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_par_chk    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_next  = START;
                    w_start = 1'b1;
                end
            end
            START: begin
                if (w_at_dec && w_bit) w_next = IDLE;   // glitch, not a start bit
                else if (w_at_end)     w_next = DATA;
            end
            DATA: begin
                w_shift_en = w_at_dec;
                if (w_at_end && (r_bit_cnt == LAST_BIT))
                    w_next = r_pen ? PARITY : STOP;
            end
            PARITY: begin
                w_par_chk = w_at_dec;
                if (w_at_end) w_next = STOP;
            end
            STOP: begin
                // leave half a bit early so a back-to-back start edge is caught
                if (w_at_dec) begin
                    w_next       = IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // counters, config latch, shift register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= 6'd8;
            r_pen      <= 1'b0;
            r_ptype    <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
        end else begin
            // the IDLE cycle that saw the low line counts as edge 0 of the start bit
            if (w_start)
                r_edge_cnt <= 6'd1;
            else if (r_state == IDLE || w_next == IDLE || w_at_end)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + 6'd1;

            if (r_state != DATA)
                r_bit_cnt <= '0;
            else if (w_at_end)
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;

            if (w_start) begin
                r_prescale <= bus.prescale;
                r_pen      <= bus.parity_enable;
                r_ptype    <= bus.parity_type;
                r_par_err  <= 1'b0;
            end else if (w_par_chk) begin
                r_par_err  <= (w_bit != w_exp_par);
            end

            if (w_shift_en) r_shift[r_bit_cnt] <= w_bit;
        end
    end

    // registered outputs; pulses land on the cycle after the stop decision
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pdata <= '0;
            r_dv    <= 1'b0;
            r_pe    <= 1'b0;
            r_se    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_dv   <= w_frame_done & ~r_par_err & w_bit;
            r_pe   <= w_frame_done & r_par_err;
            r_se   <= w_frame_done & ~w_bit;
            r_busy <= (w_next != IDLE);
            if (w_frame_done && !r_par_err && w_bit) r_pdata <= r_shift;
        end
    end

    assign bus.P_DATA       = r_pdata;
    assign bus.data_valid   = r_dv;
    assign bus.parity_error = r_pe;
    assign bus.stop_error   = r_se;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. Each frame driven pushes its expected outcome
// (pulse kind, byte, arrival cycle) to a scoreboard; a monitor pops and checks
// it when the receiver pulses.
// ----------------------------------------------------------------------------
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8)) bus();

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    // kind = {data_valid, parity_error, stop_error}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t        sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         busy_rise = -1;
    int         busy_fall = -1;
    int         busy_gap  = -1;
    logic       busy_q    = 1'b0;
    logic [7:0] last_good = 8'h00;
    int         last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin : mon
        logic [2:0] k;
        ev_t        e;
        k = {bus.data_valid, bus.parity_error, bus.stop_error};
        if (bus.busy && !busy_q) begin
            busy_rise = cyc;
            if (busy_fall >= 0) busy_gap = cyc - busy_fall;
        end
        if (!bus.busy && busy_q) busy_fall = cyc;
        busy_q = bus.busy;
        if (!rst && k != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, k}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {29'd0, k}, {29'd0, e.kind});
                check("pulse_cycle", cyc, e.cyc);
                if (e.kind[2]) begin
                    check("p_data", {24'd0, bus.P_DATA}, {24'd0, e.data});
                    last_good = e.data;
                end else begin
                    check("p_data_held", {24'd0, bus.P_DATA}, {24'd0, last_good});
                end
            end
        end
    end

    // all stimulus tasks start and end #1 after a rising edge
    task automatic bit_out(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    // bit with a one-clock inverted spike seen only by the centre sample
    task automatic bit_spike(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p / 2) @(posedge clk);
        #1 bus.RX_IN = ~b;
        @(posedge clk);
        #1 bus.RX_IN = b;
        repeat (p - p / 2 - 1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input int p, input logic pen, input logic pt,
                         input logic par_flip, input logic stop_b, input logic spike0);
        logic       par;
        logic [2:0] k;
        ev_t        e;
        bus.prescale      = p[5:0];
        bus.parity_enable = pen;
        bus.parity_type   = pt;
        par = (pt ? ~^d : ^d) ^ par_flip;
        k   = {(!par_flip && stop_b), par_flip, !stop_b};
        e.kind = k;
        e.data = d;
        e.cyc  = cyc + (9 + int'(pen)) * p + p / 2 + 5;
        sb.push_back(e);
        last_start = cyc;
        bit_out(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            if (spike0 && i == 0) bit_spike(d[i], p);
            else                  bit_out(d[i], p);
        end
        if (pen) bit_out(par, p);
        bit_out(stop_b, p);
        bus.RX_IN = 1'b1;
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s;
        bus.RX_IN         = 1'b1;
        bus.prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_p_data", {24'd0, bus.P_DATA}, 32'd0);
        check("rst_dv",     {31'd0, bus.data_valid}, 32'd0);
        check("rst_pe",     {31'd0, bus.parity_error}, 32'd0);
        check("rst_se",     {31'd0, bus.stop_error}, 32'd0);
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        idle(16);

        // P=8, no parity, 0xA5: 81-cycle latency checked by the monitor
        frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        check("busy_rise_delay", busy_rise - last_start, 32'd3);
        check("busy_idle_a5", {31'd0, bus.busy}, 32'd0);
        idle(16);

        // P=16 even parity: good then bad parity bit
        frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        idle(32);
        frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drain(200);
        idle(32);

        // P=8 stop bit low, then a normal frame
        frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(200);
        idle(32);
        frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        idle(32);

        // P=16 three-clock low glitch: short busy blip, no pulses
        bus.prescale = 6'd16;
        s = cyc;
        bus.RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.RX_IN = 1'b1;
        idle(64);
        check("glitch_busy_rise", busy_rise - s, 32'd3);
        check("glitch_busy_short", {31'd0, (busy_fall > busy_rise) && (busy_fall - busy_rise < 16)}, 32'd1);
        check("glitch_busy_idle", {31'd0, bus.busy}, 32'd0);
        check("glitch_no_pulse", sb.size(), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // spike on the centre sample of data bit 0 is outvoted
        frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drain(300);
        idle(32);
`endif

        // P=32 odd parity, back-to-back frames with one stop bit between them
        frame(8'h55, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        frame(8'hAA, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drain(600);
        check("b2b_busy_gap", {31'd0, (busy_gap > 0) && (busy_gap < 32)}, 32'd1);
        idle(64);

        // reset in the middle of DATA of 0xF9; remaining line stays high
        bus.prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        bit_out(1'b0, 8);
        bit_out(1'b1, 8);
        bit_out(1'b0, 8);
        bit_out(1'b0, 8);
        bus.RX_IN = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_good = 8'h00;
        check("midrst_p_data", {24'd0, bus.P_DATA}, 32'd0);
        check("midrst_dv",     {31'd0, bus.data_valid}, 32'd0);
        check("midrst_pe",     {31'd0, bus.parity_error}, 32'd0);
        check("midrst_se",     {31'd0, bus.stop_error}, 32'd0);
        check("midrst_busy",   {31'd0, bus.busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 4; i < 8; i++) bit_out(1'b1, 8);
        bit_out(1'b1, 8);
        idle(48);
        check("midrst_no_pulse", sb.size(), 32'd0);
        check("midrst_busy_idle", {31'd0, bus.busy}, 32'd0);
        frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        idle(16);

        check("final_sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
